// File: rtl/watch_set_ctrl.sv
// Time-setting controller for the hh:mm watch.
// Two raw buttons are synchronised and debounced into single-cycle press
// pulses. bt0 walks the edit FSM through hours, tens of minutes and minute
// units, then issues a one-cycle load strobe. bt1 increments the field being
// edited. The edited field blinks through the blank_* outputs. An edit that
// sits idle for TIMEOUT_CYC cycles is abandoned without loading.
module watch_set_ctrl #(
    parameter int DEBOUNCE_CYC = 655,
    parameter int BLINK_CYC    = 8192,
    parameter int TIMEOUT_CYC  = 983040
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       bt0_i,
    input  logic       bt1_i,
    input  logic [4:0] cur_hhxx_i,
    input  logic [2:0] cur_xxmx_i,
    input  logic [3:0] cur_xxxm_i,
    output logic [4:0] cfg_hhxx_o,
    output logic [2:0] cfg_xxmx_o,
    output logic [3:0] cfg_xxxm_o,
    output logic       load_o,
    output logic       editing_o,
    output logic       blank_hh_o,
    output logic       blank_mx_o,
    output logic       blank_xm_o
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BL_W = (BLINK_CYC    > 1) ? $clog2(BLINK_CYC)    : 1;
    localparam int TO_W = (TIMEOUT_CYC  > 1) ? $clog2(TIMEOUT_CYC)  : 1;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_H   = 3'd1,
        SET_M10 = 3'd2,
        SET_M1  = 3'd3,
        LOAD    = 3'd4
    } state_t;

    // Bit 0 carries bt0, bit 1 carries bt1 through the whole input path.
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      db_lvl;
    logic [1:0]      db_lvl_d;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    state_t          state;
    logic [TO_W-1:0] idle_cnt;
    logic [BL_W-1:0] blink_cnt;
    logic            phase;
    logic            blink_wrap;
    logic            phase_nx;

    // Increment a field value, wrapping to 0 after the top legal value.
    function automatic logic [4:0] inc_wrap(input logic [4:0] v, input logic [4:0] top);
        return (v >= top) ? 5'd0 : v + 5'd1;
    endfunction

    // Replace an out-of-range captured value with 0.
    function automatic logic [4:0] in_range(input logic [4:0] v, input logic [4:0] top);
        return (v > top) ? 5'd0 : v;
    endfunction

    assign blink_wrap = (blink_cnt == BL_MAX);
    assign phase_nx   = phase ^ blink_wrap;

    // Synchronise, debounce and edge-detect both buttons.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0  <= {bt1_i, bt0_i};
            sync_p1  <= sync_p0;
            db_lvl_d <= db_lvl;
            press    <= db_lvl & ~db_lvl_d;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        db_lvl[i] <= sync_p1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Edit FSM with idle timeout, blink phase and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= RUN;
            cfg_hhxx_o <= '0;
            cfg_xxmx_o <= '0;
            cfg_xxxm_o <= '0;
            load_o     <= 1'b0;
            editing_o  <= 1'b0;
            blank_hh_o <= 1'b0;
            blank_mx_o <= 1'b0;
            blank_xm_o <= 1'b0;
            idle_cnt   <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
        end else begin
            load_o     <= 1'b0;
            blank_hh_o <= 1'b0;
            blank_mx_o <= 1'b0;
            blank_xm_o <= 1'b0;
            case (state)
                RUN: begin
                    editing_o <= 1'b0;
                    if (press[0]) begin
                        state      <= SET_H;
                        editing_o  <= 1'b1;
                        cfg_hhxx_o <= in_range(cur_hhxx_i, 5'd23);
                        cfg_xxmx_o <= 3'(in_range({2'b00, cur_xxmx_i}, 5'd5));
                        cfg_xxxm_o <= 4'(in_range({1'b0, cur_xxxm_i}, 5'd9));
                        idle_cnt   <= '0;
                        blink_cnt  <= '0;
                        phase      <= 1'b0;
                    end
                end
                SET_H, SET_M10, SET_M1: begin
                    editing_o <= 1'b1;
                    if (press[0]) begin
                        // Mode press wins over a simultaneous increment press.
                        idle_cnt  <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                        case (state)
                            SET_H:   state <= SET_M10;
                            SET_M10: state <= SET_M1;
                            default: begin
                                state  <= LOAD;
                                load_o <= 1'b1;
                            end
                        endcase
                    end else if (press[1]) begin
                        // An increment restarts both the idle timer and the blink, so the new digit shows.
                        idle_cnt  <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                        case (state)
                            SET_H:   cfg_hhxx_o <= inc_wrap(cfg_hhxx_o, 5'd23);
                            SET_M10: cfg_xxmx_o <= 3'(inc_wrap({2'b00, cfg_xxmx_o}, 5'd5));
                            default: cfg_xxxm_o <= 4'(inc_wrap({1'b0, cfg_xxxm_o}, 5'd9));
                        endcase
                    end else if (idle_cnt == TO_MAX) begin
                        state     <= RUN;
                        editing_o <= 1'b0;
                    end else begin
                        idle_cnt  <= idle_cnt + TO_W'(1);
                        blink_cnt <= blink_wrap ? '0 : blink_cnt + BL_W'(1);
                        phase     <= phase_nx;
                        case (state)
                            SET_H:   blank_hh_o <= phase_nx;
                            SET_M10: blank_mx_o <= phase_nx;
                            default: blank_xm_o <= phase_nx;
                        endcase
                    end
                end
                LOAD: begin
                    state     <= RUN;
                    editing_o <= 1'b0;
                end
                default: begin
                    state     <= RUN;
                    editing_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
